flag_branch_ctrl: RTL and testbench

Conditional-branch controller for the pipelined CPU's flag registers. It gates the flag-register write enable and resolves B.cond in ID against either the committed flags or the EX-stage ALU flags. It stalls the front end when flags are not yet valid and issues branch-taken and IF-flush. It also keeps saturating branch statistics counters for debug.

---
 rtl/flag_branch_ctrl.sv | 112 +++++++++++
 tb/tb_flag_branch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_ctrl.sv
// B.cond resolution and flag-register write gating, with optional EX flag forwarding
// and saturating debug counters for resolved and taken branches.
module flag_branch_ctrl #(
    parameter bit          FORWARD = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             id_valid,
    input  logic             id_is_bcond,
    input  logic [3:0]       id_cond,
    input  logic             ex_valid,
    input  logic             ex_setflags,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    input  logic             zeroReg,
    input  logic             negativeReg,
    input  logic             overflReg,
    input  logic             carry_oReg,
    output logic             setflags,
    output logic             stall_out,
    output logic             br_taken,
    output logic             flush_if,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [0:0] {StRun, StHold} state_t;

    state_t state_q;
    logic   bcond, hazard, resolve, use_alu, go_hold, cond_res, taken;
    logic   fz, fn, fv, fc;

    function automatic logic cond_eval(input logic [3:0] c, input logic z, input logic n,
                                       input logic v, input logic cy);
        case (c)
            4'b0000: return z;
            4'b0001: return ~z;
            4'b0010: return cy;
            4'b0011: return ~cy;
            4'b0100: return n;
            4'b0101: return ~n;
            4'b0110: return v;
            4'b0111: return ~v;
            4'b1000: return cy & ~z;
            4'b1001: return ~cy | z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return ~z & (n == v);
            4'b1101: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        bcond   = id_valid & id_is_bcond;
        hazard  = bcond & ex_valid & ex_setflags;
        resolve = 1'b0;
        use_alu = 1'b0;
        go_hold = 1'b0;
        if (!reset && !stall_in) begin
            case (state_q)
                StRun: begin
                    if (bcond) begin
                        if (!hazard) begin
                            resolve = 1'b1;
                        end else if (FORWARD) begin
                            resolve = 1'b1;
                            use_alu = 1'b1;
                        end else begin
                            go_hold = 1'b1;
                        end
                    end
                end
                // EX holds the injected bubble, so committed flags are now current
                StHold:  resolve = bcond;
                default: resolve = 1'b0;
            endcase
        end
        fz       = use_alu ? alu_zero      : zeroReg;
        fn       = use_alu ? alu_negative  : negativeReg;
        fv       = use_alu ? alu_overflow  : overflReg;
        fc       = use_alu ? alu_carry_out : carry_oReg;
        cond_res = cond_eval(id_cond, fz, fn, fv, fc);
        taken    = resolve & cond_res;
    end

    assign setflags  = ~reset & ex_valid & ex_setflags & ~stall_in;
    assign stall_out = go_hold;
    assign br_taken  = taken;
    assign flush_if  = taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            br_count    <= '0;
            taken_count <= '0;
        end else if (!stall_in) begin
            state_q <= go_hold ? StHold : StRun;
            if (resolve && br_count != {CNT_W{1'b1}}) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (taken && taken_count != {CNT_W{1'b1}}) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Directed bench for flag_branch_ctrl: three instances (forwarding, stalling,
// stalling with 2-bit counters) share one stimulus stream.
module tb_flag_branch_ctrl;

    logic       clk = 1'b0;
    logic       reset, stall_in, id_valid, id_is_bcond, ex_valid, ex_setflags;
    logic [3:0] id_cond;
    logic       alu_zero, alu_negative, alu_overflow, alu_carry_out;
    logic       zeroReg, negativeReg, overflReg, carry_oReg;

    logic        sf1, st1, bt1, fl1;
    logic [15:0] bc1, tc1;
    logic        sf0, st0, bt0, fl0;
    logic [15:0] bc0, tc0;
    logic        sf2, st2, bt2, fl2;
    logic [1:0]  bc2, tc2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    flag_branch_ctrl #(.FORWARD(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .reset(reset), .stall_in(stall_in), .id_valid(id_valid),
        .id_is_bcond(id_is_bcond), .id_cond(id_cond), .ex_valid(ex_valid),
        .ex_setflags(ex_setflags), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .zeroReg(zeroReg),
        .negativeReg(negativeReg), .overflReg(overflReg), .carry_oReg(carry_oReg),
        .setflags(sf1), .stall_out(st1), .br_taken(bt1), .flush_if(fl1),
        .br_count(bc1), .taken_count(tc1)
    );

    flag_branch_ctrl #(.FORWARD(1'b0), .CNT_W(16)) u_stl (
        .clk(clk), .reset(reset), .stall_in(stall_in), .id_valid(id_valid),
        .id_is_bcond(id_is_bcond), .id_cond(id_cond), .ex_valid(ex_valid),
        .ex_setflags(ex_setflags), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .zeroReg(zeroReg),
        .negativeReg(negativeReg), .overflReg(overflReg), .carry_oReg(carry_oReg),
        .setflags(sf0), .stall_out(st0), .br_taken(bt0), .flush_if(fl0),
        .br_count(bc0), .taken_count(tc0)
    );

    flag_branch_ctrl #(.FORWARD(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .stall_in(stall_in), .id_valid(id_valid),
        .id_is_bcond(id_is_bcond), .id_cond(id_cond), .ex_valid(ex_valid),
        .ex_setflags(ex_setflags), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .zeroReg(zeroReg),
        .negativeReg(negativeReg), .overflReg(overflReg), .carry_oReg(carry_oReg),
        .setflags(sf2), .stall_out(st2), .br_taken(bt2), .flush_if(fl2),
        .br_count(bc2), .taken_count(tc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs are then driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        stall_in = 0; id_valid = 0; id_is_bcond = 0; id_cond = 4'd0;
        ex_valid = 0; ex_setflags = 0;
        alu_zero = 0; alu_negative = 0; alu_overflow = 0; alu_carry_out = 0;
        zeroReg = 0; negativeReg = 0; overflReg = 0; carry_oReg = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic bcond(input logic [3:0] c);
        id_valid = 1; id_is_bcond = 1; id_cond = c;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #1;
        // Outputs forced low while reset is high, even with a hazard and an AL branch.
        ex_valid = 1; ex_setflags = 1; bcond(4'b1110);
        settle();
        check("rst_setflags", 32'(sf1), 32'd0);
        check("rst_br_taken", 32'(bt1), 32'd0);
        check("rst_stall_out", 32'(st0), 32'd0);
        step();
        step();
        clear_inputs();
        reset = 0;
        repeat (3) step();
        settle();
        check("idle_setflags", 32'(sf1), 32'd0);
        check("idle_stall_out", 32'(st1), 32'd0);
        check("idle_br_taken", 32'(bt1), 32'd0);
        check("idle_flush_if", 32'(fl1), 32'd0);
        check("idle_br_count", 32'(bc1), 32'd0);
        check("idle_taken_count", 32'(tc1), 32'd0);
        check("idle_stl_br_count", 32'(bc0), 32'd0);

        // SUBS in EX yields Z=1, committed Z=0, B.EQ in ID.
        ex_valid = 1; ex_setflags = 1; alu_zero = 1; zeroReg = 0; bcond(4'b0000);
        settle();
        check("fwd_br_taken", 32'(bt1), 32'd1);
        check("fwd_flush_if", 32'(fl1), 32'd1);
        check("fwd_stall_out", 32'(st1), 32'd0);
        check("fwd_setflags", 32'(sf1), 32'd1);
        check("stl_c0_stall_out", 32'(st0), 32'd1);
        check("stl_c0_br_taken", 32'(bt0), 32'd0);
        check("stl_c0_setflags", 32'(sf0), 32'd1);
        step();
        check("fwd_br_count", 32'(bc1), 32'd1);
        check("fwd_taken_count", 32'(tc1), 32'd1);
        check("stl_c0_br_count", 32'(bc0), 32'd0);
        ex_valid = 0; ex_setflags = 0; alu_zero = 0; zeroReg = 1;
        settle();
        check("stl_c1_br_taken", 32'(bt0), 32'd1);
        check("stl_c1_flush_if", 32'(fl0), 32'd1);
        check("stl_c1_stall_out", 32'(st0), 32'd0);
        step();
        check("stl_c1_br_count", 32'(bc0), 32'd1);
        check("stl_c1_taken_count", 32'(tc0), 32'd1);

        // No hazard: N=1, V=0; B.GE not taken, B.LT taken.
        clear_inputs();
        do_reset();
        negativeReg = 1; overflReg = 0; bcond(4'b1010);
        settle();
        check("ge_br_taken", 32'(bt1), 32'd0);
        check("ge_stl_br_taken", 32'(bt0), 32'd0);
        step();
        bcond(4'b1011);
        settle();
        check("lt_br_taken", 32'(bt1), 32'd1);
        step();
        check("nohz_br_count", 32'(bc1), 32'd2);
        check("nohz_taken_count", 32'(tc1), 32'd1);
        check("nohz_stl_br_count", 32'(bc0), 32'd2);
        check("nohz_stl_taken_count", 32'(tc0), 32'd1);

        // Hazard frozen by stall_in for two cycles, then released.
        clear_inputs();
        do_reset();
        ex_valid = 1; ex_setflags = 1; alu_zero = 1; bcond(4'b0000); stall_in = 1;
        settle();
        check("sin_setflags", 32'(sf1), 32'd0);
        check("sin_br_taken", 32'(bt1), 32'd0);
        check("sin_stl_stall_out", 32'(st0), 32'd0);
        step();
        step();
        check("sin_br_count", 32'(bc1), 32'd0);
        check("sin_taken_count", 32'(tc1), 32'd0);
        stall_in = 0;
        settle();
        check("rel_br_taken", 32'(bt1), 32'd1);
        check("rel_stl_stall_out", 32'(st0), 32'd1);
        step();
        check("rel_br_count", 32'(bc1), 32'd1);
        // Stall arrives while the stalling instance sits in HOLD.
        ex_valid = 0; ex_setflags = 0; alu_zero = 0; zeroReg = 1; stall_in = 1;
        settle();
        check("hold_sin_br_taken", 32'(bt0), 32'd0);
        step();
        check("hold_sin_br_count", 32'(bc0), 32'd0);
        stall_in = 0;
        settle();
        check("hold_rel_br_taken", 32'(bt0), 32'd1);
        check("hold_rel_stall_out", 32'(st0), 32'd0);
        step();
        check("hold_rel_br_count", 32'(bc0), 32'd1);

        // Five taken AL branches saturate the 2-bit counters.
        clear_inputs();
        do_reset();
        bcond(4'b1110);
        repeat (5) step();
        check("sat_br_count", 32'(bc2), 32'd3);
        check("sat_taken_count", 32'(tc2), 32'd3);
        check("wide_br_count", 32'(bc1), 32'd5);

        // Reset while in HOLD: pending branch discarded, back in RUN.
        ex_valid = 1; ex_setflags = 1;
        settle();
        check("hz_sat_stall_out", 32'(st2), 32'd1);
        step();
        reset = 1;
        settle();
        check("hold_rst_br_taken", 32'(bt2), 32'd0);
        step();
        reset = 0;
        settle();
        check("post_rst_stall_out", 32'(st2), 32'd1);
        check("post_rst_br_taken", 32'(bt2), 32'd0);
        check("post_rst_br_count", 32'(bc2), 32'd0);
        check("post_rst_taken_count", 32'(tc2), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
